// File: rtl/test_pkg.sv
// Shared opcode, state and command types for the command issue path
// feeding test_mod.
package test_pkg;

  typedef logic [2:0] chris_t;

  localparam chris_t OP_NOP   = 3'd0;
  localparam chris_t OP_FLUSH = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } cmd_state_e;

  typedef struct packed {
    chris_t      op;
    logic [7:0]  data;
  } cmd_t;

endpackage

// File: rtl/cmd_ring_buf.sv
// Circular command store behind the output register: storage,
// wrapping pointers and occupancy, with clear taking priority.
module cmd_ring_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  import test_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_clear)
      r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + 1'b1;
      if (i_pop)
        r_rptr <= r_rptr + 1'b1;
      if (i_push && !i_pop)
        r_count <= r_count + 1'b1;
      else if (!i_push && i_pop)
        r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cmd_issue_queue.sv
// Command stage ahead of test_mod: drops NOPs, executes FLUSH locally,
// forwards everything else in order through a ring buffer.
module cmd_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               nop_cnt,
  output logic                     busy
);
  import test_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = 3 + DATA_W;

  cmd_state_e          r_state;
  cmd_state_e          w_state_nxt;
  logic                r_out_valid;
  chris_t              r_out_op;
  logic [DATA_W-1:0]   r_out_data;
  logic [7:0]          r_nop_cnt;

  logic                w_in_fire;
  logic                w_is_nop;
  logic                w_is_flush;
  logic                w_fwd;
  logic                w_flush_acc;
  logic                w_pop;
  logic                w_load;
  logic                w_bypass;
  logic                w_rb_push;
  logic                w_rb_pop;
  logic                w_rb_clear;
  logic                w_rb_empty;
  logic [W-1:0]        w_rb_rdata;
  logic [CW-1:0]       w_rb_count;
  logic [CW-1:0]       w_count;
  logic                w_busy_nxt;

  assign w_count = w_rb_count + CW'(r_out_valid);

  assign in_ready = rst_n && (w_count < CW'(DEPTH))
                  && (r_state != FLUSH);

  assign w_in_fire   = in_valid && in_ready;
  assign w_is_nop    = (in_op == OP_NOP);
  assign w_is_flush  = (in_op == OP_FLUSH);
  assign w_fwd       = w_in_fire && !w_is_nop && !w_is_flush;
  assign w_flush_acc = w_in_fire && w_is_flush;

  assign w_pop    = r_out_valid && out_ready;
  assign w_load   = !r_out_valid || w_pop;
  // An empty buffer lets a new command go straight to the output register.
  assign w_bypass   = w_load && w_rb_empty && w_fwd;
  assign w_rb_push  = w_fwd && !w_bypass;
  assign w_rb_pop   = w_load && !w_rb_empty && !w_flush_acc;
  assign w_rb_clear = w_flush_acc || (r_state == FLUSH);

  cmd_ring_buf #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_rb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rb_push),
    .i_pop   (w_rb_pop),
    .i_clear (w_rb_clear),
    .i_wdata ({in_op, in_data}),
    .o_rdata (w_rb_rdata),
    .o_count (w_rb_count),
    .o_empty (w_rb_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_data  <= '0;
    end else if (w_flush_acc || r_state == FLUSH) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (!w_rb_empty) begin
        r_out_valid <= 1'b1;
        r_out_op    <= w_rb_rdata[W-1 -: 3];
        r_out_data  <= w_rb_rdata[DATA_W-1:0];
      end else if (w_fwd) begin
        r_out_valid <= 1'b1;
        r_out_op    <= in_op;
        r_out_data  <= in_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_nop_cnt <= '0;
    else if (w_in_fire && w_is_nop && r_nop_cnt != 8'hFF)
      r_nop_cnt <= r_nop_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Stage stays busy while anything remains after this cycle's traffic.
  assign w_busy_nxt = w_fwd || (w_count > CW'(w_pop));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, ISSUE: begin
        if (w_flush_acc)
          w_state_nxt = FLUSH;
        else if (w_busy_nxt)
          w_state_nxt = ISSUE;
        else
          w_state_nxt = IDLE;
      end
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_valid = r_out_valid;
  assign out_op    = r_out_op;
  assign out_data  = r_out_data;
  assign count     = w_count;
  assign nop_cnt   = r_nop_cnt;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Scoreboard bench for cmd_issue_queue: directed stimulus queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_cmd_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic [7:0]  nop_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [10:0] sbq[$];

  always #5 clk = ~clk;

  cmd_issue_queue #(.DEPTH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_data  (out_data),
    .count     (count),
    .nop_cnt   (nop_cnt),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got op=%0d data=%0h expected none",
                 out_op, out_data);
      end else begin
        logic [10:0] e;
        e = sbq.pop_front();
        if ({out_op, out_data} !== e) begin
          errors++;
          $display("FAIL out_cmd: got op=%0d data=%0h expected op=%0d data=%0h",
                   out_op, out_data, e[10:8], e[7:0]);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (op != 3'd0 && op != 3'd7)
        sbq.push_back({op, d});
      @(posedge clk);
      #1;
    end else begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 op=%0d", op);
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_nop_cnt", nop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    chk("idle_in_ready", in_ready, 1);

    // basic in-order pass-through
    out_ready = 1'b1;
    send(3'd1, 8'h11);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_op", out_op, 1);
    chk("lat_busy", busy, 1);
    send(3'd2, 8'h22);
    send(3'd3, 8'h33);
    cycles(3);
    chk("drain_count", count, 0);
    chk("drain_busy", busy, 0);

    // fill to full, then drain with a fifth pending
    out_ready = 1'b0;
    send(3'd1, 8'hA1);
    send(3'd2, 8'hA2);
    send(3'd3, 8'hA3);
    send(3'd4, 8'hA4);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    fork
      send(3'd5, 8'hA5);
      begin
        @(negedge clk);
        chk("full_hold_ready", in_ready, 0);
        chk("full_hold_count", count, 4);
        out_ready = 1'b1;
      end
    join
    cycles(6);
    chk("full_drain_count", count, 0);

    // stall: output held while inputs wiggle
    out_ready = 1'b0;
    send(3'd6, 8'h66);
    for (int i = 0; i < 3; i++) begin
      in_op   = 3'(i + 1);
      in_data = 8'(8'h90 + i);
      @(negedge clk);
      chk("stall_op", out_op, 6);
      chk("stall_data", out_data, 8'h66);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    cycles(3);

    // NOP filtering and counter saturation
    for (int i = 0; i < 300; i++) begin
      send(3'd0, 8'(i));
      if (i == 10)
        chk("nop_cnt_11", nop_cnt, 11);
      if (i == 150)
        send(3'd4, 8'h44);
    end
    cycles(3);
    chk("nop_sat", nop_cnt, 255);
    chk("nop_count", count, 0);

    // FLUSH with head transferring in the same cycle
    out_ready = 1'b0;
    send(3'd1, 8'hB1);
    send(3'd2, 8'hB2);
    send(3'd3, 8'hB3);
    chk("pre_flush_count", count, 3);
    out_ready = 1'b1;
    send(3'd7, 8'h00);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 1);
    sbq.delete();
    cycles(1);
    chk("post_flush_count", count, 0);
    chk("post_flush_busy", busy, 0);
    chk("post_flush_ready", in_ready, 1);
    send(3'd2, 8'hC2);
    cycles(2);

    // asynchronous reset mid-drain
    out_ready = 1'b0;
    send(3'd1, 8'hD1);
    send(3'd2, 8'hD2);
    chk("pre_rst_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    send(3'd5, 8'h55);
    chk("rst_new_op", out_op, 5);
    chk("rst_new_data", out_data, 8'h55);
    cycles(3);
    chk("sb_empty", sbq.size(), 0);
    chk("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_issue_queue.md
Name: cmd_issue_queue

Overview:
- Buffered command stage that sits directly upstream of test_mod and feeds it 3-bit opcodes (chris_t) with a data payload over a valid/ready handshake.
- Filters NOP commands and executes FLUSH commands locally.
- Forwards every other command in order through a DEPTH-entry circular queue.
- Reports occupancy and a saturating NOP counter for debug.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 8, payload width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  stage can accept a command this cycle.
- in_op  input  3  command opcode (chris_t).
- in_data  input  DATA_W  command payload.
- out_valid  output  1  command presented to test_mod.
- out_ready  input  1  test_mod accepts the command.
- out_op  output  3  forwarded opcode.
- out_data  output  DATA_W  forwarded payload.
- count  output  $clog2(DEPTH)+1  entries held, including the output register.
- nop_cnt  output  8  saturating count of NOPs dropped.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release): in_ready=0 during reset, out_valid=0, out_op=0, out_data=0, count=0, nop_cnt=0, busy=0, state=IDLE, read/write pointers cleared.
- Input handshake:
  - An input transfer occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH) && state != FLUSH. It is registered-free (combinational from state and count).
- Opcodes (OP_NOP=3'd0, OP_FLUSH=3'd7, all others forwarded):
  - NOP: accepted and discarded. nop_cnt increments, saturating at 255.
  - FLUSH: accepted, not enqueued. Next state is FLUSH.
  - Other opcodes: written to the queue.
- Output side:
  - The head entry is held in an output register (out_valid, out_op, out_data).
  - An output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_op and out_data are held stable.
- Latency: a command accepted at edge N into an empty stage is presented with out_valid=1 after edge N. There is no bubble when draining back-to-back with out_ready held high: throughput is 1 per cycle.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Full/empty:
  - count==DEPTH forces in_ready=0.
  - A push and a pop in the same cycle while full is not allowed, because in_ready is already low.
  - A push and a pop in the same cycle while not full leaves count unchanged.
- FSM:
  - IDLE (count==0) -> ISSUE on a forwarded push.
  - ISSUE -> IDLE when the last entry pops with no push in the same cycle.
  - ISSUE -> FLUSH on an accepted FLUSH.
  - IDLE -> FLUSH on an accepted FLUSH.
  - FLUSH lasts exactly one cycle: pointers cleared, count=0, out_valid=0, in_ready=0. It then goes to IDLE.
- FLUSH vs output: if the output register is valid when FLUSH is accepted and out_ready is high that same cycle, that output transfer completes. All remaining entries are discarded.
- out_ready is ignored when out_valid=0.
- Reset mid-stream discards all contents immediately. out_valid drops asynchronously.

Decomposition:
- test_pkg additions:
  - OP_NOP and OP_FLUSH localparams of type chris_t.
  - cmd_state_e enum {IDLE, ISSUE, FLUSH}, encoded as logic [1:0].
  - cmd_t packed struct {chris_t op; logic [7:0] data;}.
- The module imports test_pkg::*.
- One sub-module: cmd_ring_buf. It holds the storage array, the pointers and count, with push, pop and clear inputs. cmd_issue_queue holds the FSM, the opcode filter, the output register and nop_cnt.

Test Plan:
- Reset, then push ops 1,2,3 with data 0x11,0x22,0x33, out_ready=1 -> out_valid one cycle after each push; outputs (1,0x11),(2,0x22),(3,0x33) in order; count returns to 0; busy falls.
- out_ready=0, push 5 commands -> first 4 accepted, count=4, in_ready=0 on the 5th. Then out_ready=1 -> 4 commands drain in order, and the 5th is accepted when count drops to 3.
- Stall: out_valid=1 with out_ready=0 for 3 cycles while in_op/in_data change -> out_op/out_data unchanged throughout.
- Push NOP x300 interleaved with op 4 -> nop_cnt saturates at 255; no NOP appears on the output; op 4 is delivered.
- Fill with 3 entries, then FLUSH with out_ready=1 -> head entry transfers; for one cycle in_ready=0 and out_valid=0; the next cycle count=0 and state=IDLE.
- Assert rst_n=0 mid-drain with count=2 -> out_valid=0 and count=0 without waiting for a clock edge; after release, a new push emerges correctly.
